// File: rtl/mips_pc_pkg.sv
// Shared types and default constants for the MIPS program-counter sequencer.
// Vector defaults match the boot ROM map (kseg1 reset / general exception).
package mips_pc_pkg;

  typedef enum logic [1:0] {
    SEQ   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
  localparam int          DEF_INSTR_BYTES  = 4;
  localparam int          DEF_TRACE_DEPTH  = 8;

endpackage

// File: rtl/pc_trace_buffer.sv
// Ring buffer of redirect targets; index 0 reads the newest entry.
// Count saturates at DEPTH, after which the oldest entry is overwritten.
module pc_trace_buffer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [ADDR_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_wptr;
  logic [IDX_W:0]    r_count;
  logic [IDX_W-1:0]  w_slot;

  // Entry contents need no reset: reads are gated by r_count.
  always_ff @(posedge clk) begin
    if (i_wr_en && !reset) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_wr_en) begin
      r_wptr <= r_wptr + IDX_W'(1);
      if (r_count != (IDX_W+1)'(DEPTH)) r_count <= r_count + (IDX_W+1)'(1);
    end
  end

  assign w_slot    = r_wptr - IDX_W'(1) - i_rd_idx;
  assign o_rd_data = ({1'b0, i_rd_idx} < r_count) ? r_mem[w_slot] : '0;
  assign o_count   = r_count;

endmodule

// File: rtl/mips_pc_sequencer.sv
// MIPS fetch-address sequencer: sequential advance, one-slot branch delay, exceptions, ERET, halt on pc==0.
// Optional redirect trace buffer is built only when PC_TRACE_EN is defined.
module mips_pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int                TRACE_DEPTH  = DEF_TRACE_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  input  logic                           branch_valid,
  input  logic [ADDR_W-1:0]              branch_target,
  input  logic                           exception,
  input  logic                           eret,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [ADDR_W-1:0]              pc,
  output logic                           active,
  output logic                           in_delay_slot,
  output logic [ADDR_W-1:0]              epc,
  output logic                           exc_bd,
  output logic                           addr_fault,
  output logic [ADDR_W-1:0]              trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);
  localparam logic [ADDR_W-1:0] IB = ADDR_W'(INSTR_BYTES);

  pc_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_target, r_epc;
  logic              r_exc_bd, r_addr_fault;
  logic [ADDR_W-1:0] w_pc_nxt, w_target_nxt, w_epc_nxt, w_pc_seq;
  logic              w_exc_bd_nxt, w_fault, w_redirect;
  logic              w_tgt_mis, w_epc_mis;

  assign w_pc_seq  = r_pc + IB;
  assign w_tgt_mis = (branch_target % IB) != '0;
  assign w_epc_mis = (r_epc % IB) != '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    w_epc_nxt    = r_epc;
    w_exc_bd_nxt = r_exc_bd;
    w_fault      = 1'b0;
    w_redirect   = 1'b0;
    if (r_state != HALT) begin
      // A misaligned redirect is only a fault if it would actually have been taken.
      w_fault = !exception && ((eret && w_epc_mis) ||
                (!eret && branch_valid && r_state == SEQ && w_tgt_mis));
      if (exception || w_fault) begin
        w_pc_nxt    = EXC_VECTOR;
        w_state_nxt = SEQ;
        w_redirect  = 1'b1;
        if (exception && r_state == DELAY) begin
          w_epc_nxt    = r_pc - IB;
          w_exc_bd_nxt = 1'b1;
        end else begin
          w_epc_nxt    = r_pc;
          w_exc_bd_nxt = 1'b0;
        end
      end else if (eret) begin
        w_pc_nxt    = r_epc;
        w_state_nxt = SEQ;
        w_redirect  = 1'b1;
      end else if (r_state == DELAY) begin
        w_pc_nxt    = r_target;
        w_state_nxt = SEQ;
        w_redirect  = 1'b1;
      end else if (branch_valid) begin
        w_target_nxt = branch_target;
        w_pc_nxt     = w_pc_seq;
        w_state_nxt  = DELAY;
      end else begin
        w_pc_nxt = w_pc_seq;
      end
      if (w_pc_nxt == '0) w_state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEQ;
      r_pc         <= RESET_VECTOR;
      r_target     <= '0;
      r_epc        <= '0;
      r_exc_bd     <= 1'b0;
      r_addr_fault <= 1'b0;
    end else if (clk_enable) begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_target     <= w_target_nxt;
      r_epc        <= w_epc_nxt;
      r_exc_bd     <= w_exc_bd_nxt;
      r_addr_fault <= w_fault;
    end else begin
      r_addr_fault <= 1'b0;
    end
  end

  assign pc            = r_pc;
  assign active        = (r_state != HALT);
  assign in_delay_slot = (r_state == DELAY);
  assign epc           = r_epc;
  assign exc_bd        = r_exc_bd;
  assign addr_fault    = r_addr_fault;

`ifdef PC_TRACE_EN
  pc_trace_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (clk_enable && w_redirect),
    .i_wr_data (w_pc_nxt),
    .i_rd_idx  (trace_rd_idx),
    .o_rd_data (trace_rd_data),
    .o_count   (trace_count)
  );
`else
  logic w_unused;
  assign w_unused      = ^{trace_rd_idx, w_redirect};
  assign trace_rd_data = '0;
  assign trace_count   = '0;
`endif

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer; trace checks adapt to the PC_TRACE_EN build.
module tb_mips_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, clk_enable, branch_valid, exception, eret;
  logic [31:0] branch_target;
  logic [2:0]  trace_rd_idx;
  logic [31:0] pc, epc, trace_rd_data;
  logic        active, in_delay_slot, exc_bd, addr_fault;
  logic [3:0]  trace_count;

  int n_checks = 0;
  int n_errors = 0;

  mips_pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .exception     (exception),
    .eret          (eret),
    .trace_rd_idx  (trace_rd_idx),
    .pc            (pc),
    .active        (active),
    .in_delay_slot (in_delay_slot),
    .epc           (epc),
    .exc_bd        (exc_bd),
    .addr_fault    (addr_fault),
    .trace_rd_data (trace_rd_data),
    .trace_count   (trace_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; branch_valid = 1'b0; exception = 1'b0;
    eret = 1'b0; branch_target = '0; trace_rd_idx = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pc", pc, 32'hBFC00000);
    check("rst_active", {31'd0, active}, 1);
    check("rst_ds", {31'd0, in_delay_slot}, 0);
    check("rst_epc", epc, 0);
    check("rst_bd", {31'd0, exc_bd}, 0);
    check("rst_fault", {31'd0, addr_fault}, 0);
    check("rst_tcount", {28'd0, trace_count}, 0);
    check("rst_tdata", trace_rd_data, 0);

    tick(); check("seq1", pc, 32'hBFC00004);
    tick(); check("seq2", pc, 32'hBFC00008);
    check("seq_active", {31'd0, active}, 1);

    // Branch with delay slot
    branch_valid = 1'b1; branch_target = 32'hBFC00100;
    tick(); branch_valid = 1'b0;
    check("br_slot_pc", pc, 32'hBFC0000C);
    check("br_slot_ds", {31'd0, in_delay_slot}, 1);
    tick(); check("br_taken", pc, 32'hBFC00100);
    check("br_taken_ds", {31'd0, in_delay_slot}, 0);

    // Exception inside the delay slot, then ERET back to the branch
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    tick(); branch_valid = 1'b0;
    check("exds_slot", pc, 32'hBFC00104);
    exception = 1'b1;
    tick(); exception = 1'b0;
    check("exds_pc", pc, 32'hBFC00380);
    check("exds_epc", epc, 32'hBFC00100);
    check("exds_bd", {31'd0, exc_bd}, 1);
    check("exds_ds", {31'd0, in_delay_slot}, 0);
    eret = 1'b1;
    tick(); eret = 1'b0;
    check("eret_pc", pc, 32'hBFC00100);
    tick(); check("eret_no_pending", pc, 32'hBFC00104);

    // Second branch in the delay slot is ignored
    branch_valid = 1'b1; branch_target = 32'hBFC00400;
    tick();
    branch_target = 32'hBFC00500;
    tick(); branch_valid = 1'b0;
    check("first_tgt_wins", pc, 32'hBFC00400);

    // Exception from SEQ
    exception = 1'b1;
    tick(); exception = 1'b0;
    check("exseq_pc", pc, 32'hBFC00380);
    check("exseq_epc", epc, 32'hBFC00400);
    check("exseq_bd", {31'd0, exc_bd}, 0);

    // Stall while in DELAY
    branch_valid = 1'b1; branch_target = 32'hBFC00600;
    tick(); branch_valid = 1'b0;
    check("stall_slot", pc, 32'hBFC00384);
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("stall_pc", pc, 32'hBFC00384);
    check("stall_ds", {31'd0, in_delay_slot}, 1);
    clk_enable = 1'b1;
    tick(); check("stall_taken", pc, 32'hBFC00600);
    tick(); check("stall_once", pc, 32'hBFC00604);

    // Misaligned branch target
    branch_valid = 1'b1; branch_target = 32'hBFC00102;
    tick(); branch_valid = 1'b0;
    check("mis_pc", pc, 32'hBFC00380);
    check("mis_fault", {31'd0, addr_fault}, 1);
    check("mis_epc", epc, 32'hBFC00604);
    check("mis_ds", {31'd0, in_delay_slot}, 0);
    tick();
    check("mis_fault_pulse", {31'd0, addr_fault}, 0);
    check("mis_next", pc, 32'hBFC00384);

    // Priority: exception over eret and branch, then eret over branch
    exception = 1'b1; eret = 1'b1; branch_valid = 1'b1; branch_target = 32'hBFC00800;
    tick(); exception = 1'b0;
    check("prio_exc_pc", pc, 32'hBFC00380);
    check("prio_exc_epc", epc, 32'hBFC00384);
    tick(); eret = 1'b0; branch_valid = 1'b0;
    check("prio_eret_pc", pc, 32'hBFC00384);
    check("prio_eret_ds", {31'd0, in_delay_slot}, 0);

`ifdef PC_TRACE_EN
    // Nine redirects so far: newest eight are 380,100,400,380,600,380,380,384
    check("trc_count", {28'd0, trace_count}, 8);
    trace_rd_idx = 3'd0; #1 check("trc_idx0", trace_rd_data, 32'hBFC00384);
    trace_rd_idx = 3'd3; #1 check("trc_idx3", trace_rd_data, 32'hBFC00600);
    trace_rd_idx = 3'd7; #1 check("trc_idx7", trace_rd_data, 32'hBFC00380);
`else
    trace_rd_idx = 3'd2;
    #1 check("trc_off_count", {28'd0, trace_count}, 0);
    check("trc_off_data", trace_rd_data, 0);
`endif

    // Branch to zero halts after the delay slot
    branch_valid = 1'b1; branch_target = 32'h0;
    tick(); branch_valid = 1'b0;
    check("halt_slot", pc, 32'hBFC00388);
    tick();
    check("halt_pc", pc, 0);
    check("halt_active", {31'd0, active}, 0);
    branch_valid = 1'b1; branch_target = 32'hBFC00100; exception = 1'b1;
    tick(); tick();
    branch_valid = 1'b0; exception = 1'b0;
    check("halt_hold_pc", pc, 0);
    check("halt_hold_active", {31'd0, active}, 0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("halt_reset_pc", pc, 32'hBFC00000);
    check("halt_reset_active", {31'd0, active}, 1);

    // Reset mid-branch discards the pending target
    branch_valid = 1'b1; branch_target = 32'hBFC00700;
    tick(); branch_valid = 1'b0;
    check("rmb_slot", pc, 32'hBFC00004);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("rmb_pc", pc, 32'hBFC00000);
    check("rmb_ds", {31'd0, in_delay_slot}, 0);
    tick(); check("rmb_seq", pc, 32'hBFC00004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
